// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode-stage definitions for the pipelined CPU
package cpu_pkg;
  localparam logic [1:0] EXT_SIGN   = 2'd0;
  localparam logic [1:0] EXT_ZERO   = 2'd1;
  localparam logic [1:0] EXT_UPPER  = 2'd2;
  localparam logic [1:0] EXT_BRANCH = 2'd3;
endpackage

// File: rtl/ext_func.sv
// ext_func: combinational immediate widening in sign, zero, upper or branch-offset form
module ext_func
  import cpu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]  x,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] y
);
  logic [OUT_W-1:0] sx;
  assign sx = {{(OUT_W-IN_W){x[IN_W-1]}}, x};
  always_comb begin
    y = mode == EXT_SIGN  ? sx :
        mode == EXT_ZERO  ? {{(OUT_W-IN_W){1'b0}}, x} :
        mode == EXT_UPPER ? {x, {(OUT_W-IN_W){1'b0}}} :
                            sx << SHAMT;
  end
endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered immediate extension with valid/ready skid buffer and flush
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_halfword,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_word,
  output logic             o_neg
);
  logic [OUT_W-1:0] f_word, skid_word;
  logic skid_valid, in_xfer, drain, main_take_in, skid_take_in, skid_valid_nxt;
  ext_func #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT(SHAMT)) u_ext (
    .x(i_halfword), .mode(i_mode), .y(f_word)
  );
  assign in_xfer        = i_valid & o_ready;
  assign drain          = o_valid & i_ready;
  // a held skid entry always has priority over the input to keep FIFO order
  assign main_take_in   = in_xfer & ~skid_valid & (~o_valid | drain);
  assign skid_take_in   = in_xfer & ~main_take_in;
  assign skid_valid_nxt = skid_take_in | (skid_valid & ~drain);
  assign o_neg          = o_word[OUT_W-1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid    <= 1'b0;
      o_word     <= '0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
      o_ready    <= 1'b1;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      skid_valid <= 1'b0;
      o_ready    <= 1'b1;
    end else begin
      o_valid    <= main_take_in | skid_valid | (o_valid & ~drain);
      skid_valid <= skid_valid_nxt;
      o_ready    <= ~skid_valid_nxt;
      if (drain & skid_valid) o_word <= skid_word;
      else if (main_take_in) o_word <= f_word;
      if (skid_take_in) skid_word <= f_word;
    end
  end
endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb_ext_unit_pipe: directed and randomized checks of ext_unit_pipe at two parameter sets
module tb_ext_unit_pipe;
  logic clk = 0, reset_n = 0;
  logic a_flush = 0, a_valid = 0, a_oready, a_ovalid, a_iready = 1, a_neg;
  logic [15:0] a_hw = 0;
  logic [1:0] a_mode = 0;
  logic [31:0] a_word;
  logic b_flush = 0, b_valid = 0, b_oready, b_ovalid, b_iready = 1, b_neg;
  logic [11:0] b_hw = 0;
  logic [1:0] b_mode = 0;
  logic [19:0] b_word;
  int errors = 0, checks = 0;
  logic [31:0] q0 [$];
  logic [19:0] q1 [$];
  logic [15:0] t_x [5];
  logic [1:0] t_m [5];
  logic [31:0] t_w [5];
  logic t_n [5];

  always #5 clk = ~clk;

  ext_unit_pipe u0 (
    .clk(clk), .reset_n(reset_n), .i_flush(a_flush), .i_valid(a_valid), .o_ready(a_oready),
    .i_halfword(a_hw), .i_mode(a_mode), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_word(a_word), .o_neg(a_neg)
  );
  ext_unit_pipe #(.IN_W(12), .OUT_W(20), .SHAMT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .i_flush(b_flush), .i_valid(b_valid), .o_ready(b_oready),
    .i_halfword(b_hw), .i_mode(b_mode), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_word(b_word), .o_neg(b_neg)
  );

  // arithmetic reference: interpret x as a number, scale, reduce modulo 2^out_w
  function automatic longint ref_f(longint x, int in_w, int out_w, int sh, int mode);
    longint m, v, r;
    m = longint'(1) << out_w;
    v = (x >= (longint'(1) << (in_w - 1))) ? x - (longint'(1) << in_w) : x;
    r = mode == 0 ? v : mode == 1 ? x : mode == 2 ? x * (longint'(1) << (out_w - in_w)) : v * (longint'(1) << sh);
    return ((r % m) + m) % m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    a_valid = 0; b_valid = 0; a_flush = 0; b_flush = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    #12;
    checks++;
    if (a_ovalid !== 1'b0 || a_word !== 32'h0 || a_neg !== 1'b0 || a_oready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: valid=%b word=%h neg=%b ready=%b, want 0 0 0 1", a_ovalid, a_word, a_neg, a_oready);
    end
    checks++;
    if (b_ovalid !== 1'b0 || b_word !== 20'h0 || b_oready !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: valid=%b word=%h ready=%b, want 0 0 1", b_ovalid, b_word, b_oready);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_modes();
    t_x = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h7FFF};
    t_m = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    t_w = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFFFFFC, 32'h0001FFFC};
    t_n = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_valid = 1; a_hw = t_x[i]; a_mode = t_m[i]; a_iready = 1;
      #1;
      if (i == 0) begin
        checks++;
        if (a_ovalid !== 1'b0) begin
          errors++;
          $display("FAIL latency: o_valid=%b before edge, want 0", a_ovalid);
        end
      end
      @(posedge clk);
      #1;
      a_valid = 0;
      checks++;
      if (a_ovalid !== 1'b1 || a_word !== t_w[i] || a_neg !== t_n[i]) begin
        errors++;
        $display("FAIL mode%0d_%h: valid=%b word=%h neg=%b, want 1 %h %b", t_m[i], t_x[i], a_ovalid, a_word, a_neg, t_w[i], t_n[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] v [3];
    logic [31:0] got [$];
    logic c_taken;
    v = '{16'h1234, 16'h8765, 16'h0F0F};
    do_reset();
    a_iready = 0; a_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_valid = 1; a_hw = v[i];
      @(posedge clk);
      #1;
      if (i >= 1) begin
        checks++;
        if (a_oready !== 1'b0 || a_ovalid !== 1'b1 || a_word !== 32'(ref_f(longint'(v[0]), 16, 32, 2, 0))) begin
          errors++;
          $display("FAIL bp_hold%0d: ready=%b valid=%b word=%h, want 0 1 %h", i, a_oready, a_ovalid, a_word, 32'(ref_f(longint'(v[0]), 16, 32, 2, 0)));
        end
      end
    end
    c_taken = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_iready = 1;
      if (c_taken) a_valid = 0;
      #1;
      if (a_ovalid) got.push_back(a_word);
      if (a_valid && a_oready) c_taken = 1;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d words, want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 32'(ref_f(longint'(v[i]), 16, 32, 2, 0))) begin
          errors++;
          $display("FAIL bp_order%0d: word=%h, want %h", i, got[i], 32'(ref_f(longint'(v[i]), 16, 32, 2, 0)));
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    a_iready = 0; a_mode = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_valid = 1; a_hw = 16'h00A0 + 16'(i);
    end
    @(negedge clk);
    a_flush = 1; a_valid = 1; a_hw = 16'hD00D;
    @(negedge clk);
    a_flush = 0; a_valid = 0;
    checks++;
    if (a_ovalid !== 1'b0 || a_oready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: valid=%b ready=%b, want 0 1", a_ovalid, a_oready);
    end
    a_iready = 1;
    a_flush = 1; a_valid = 1; a_hw = 16'hBEEF;
    @(negedge clk);
    a_flush = 0; a_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL flush_drop%0d: valid=%b word=%h, want 0", k, a_ovalid, a_word);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_iready = 0;
    @(negedge clk);
    a_valid = 1; a_hw = 16'hF00F; a_mode = 0;
    @(negedge clk);
    a_valid = 0;
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (a_ovalid !== 1'b0 || a_word !== 32'h0 || a_oready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b word=%h ready=%b, want 0 0 1", a_ovalid, a_word, a_oready);
    end
    @(negedge clk);
    reset_n = 1;
    a_iready = 1; a_valid = 1; a_hw = 16'h0042; a_mode = 3;
    @(posedge clk);
    #1;
    a_valid = 0;
    checks++;
    if (a_ovalid !== 1'b1 || a_word !== 32'h00000108) begin
      errors++;
      $display("FAIL resume: valid=%b word=%h, want 1 00000108", a_ovalid, a_word);
    end
  endtask

  task automatic test_params();
    logic [1:0] m [2];
    logic [19:0] w [2];
    m = '{2'd0, 2'd3};
    w = '{20'hFF800, 20'hFF000};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b_valid = 1; b_hw = 12'h800; b_mode = m[i]; b_iready = 1;
      @(posedge clk);
      #1;
      b_valid = 0;
      checks++;
      if (b_ovalid !== 1'b1 || b_word !== w[i] || b_neg !== 1'b1) begin
        errors++;
        $display("FAIL param_mode%0d: valid=%b word=%h neg=%b, want 1 %h 1", m[i], b_ovalid, b_word, b_neg, w[i]);
      end
    end
  endtask

  task automatic test_random();
    logic d0, d1, x0, x1;
    logic [31:0] e0;
    logic [19:0] e1;
    do_reset();
    q0.delete(); q1.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a_valid = $urandom_range(0, 3) != 0; a_hw = 16'($urandom); a_mode = 2'($urandom);
      a_iready = $urandom_range(0, 2) != 0; a_flush = $urandom_range(0, 40) == 0;
      b_valid = $urandom_range(0, 3) != 0; b_hw = 12'($urandom); b_mode = 2'($urandom);
      b_iready = $urandom_range(0, 1) != 0; b_flush = $urandom_range(0, 40) == 0;
      #1;
      checks++;
      if (a_ovalid !== (q0.size() > 0) || a_oready !== (q0.size() < 2)) begin
        errors++;
        $display("FAIL rand_a_hs c%0d: valid=%b ready=%b, want occupancy %0d", c, a_ovalid, a_oready, q0.size());
      end
      checks++;
      if (b_ovalid !== (q1.size() > 0) || b_oready !== (q1.size() < 2)) begin
        errors++;
        $display("FAIL rand_b_hs c%0d: valid=%b ready=%b, want occupancy %0d", c, b_ovalid, b_oready, q1.size());
      end
      d0 = a_ovalid & a_iready & (q0.size() > 0);
      d1 = b_ovalid & b_iready & (q1.size() > 0);
      x0 = a_valid & a_oready;
      x1 = b_valid & b_oready;
      if (d0) begin
        e0 = q0[0];
        checks++;
        if (a_word !== e0 || a_neg !== e0[31]) begin
          errors++;
          $display("FAIL rand_a_data c%0d: word=%h neg=%b, want %h %b", c, a_word, a_neg, e0, e0[31]);
        end
      end
      if (d1) begin
        e1 = q1[0];
        checks++;
        if (b_word !== e1 || b_neg !== e1[19]) begin
          errors++;
          $display("FAIL rand_b_data c%0d: word=%h neg=%b, want %h %b", c, b_word, b_neg, e1, e1[19]);
        end
      end
      @(posedge clk);
      if (a_flush) q0.delete();
      else begin
        if (d0) void'(q0.pop_front());
        if (x0) q0.push_back(32'(ref_f(longint'(a_hw), 16, 32, 2, int'(a_mode))));
      end
      if (b_flush) q1.delete();
      else begin
        if (d1) void'(q1.pop_front());
        if (x1) q1.push_back(20'(ref_f(longint'(b_hw), 12, 20, 1, int'(b_mode))));
      end
    end
    @(negedge clk);
    a_valid = 0; b_valid = 0; a_flush = 0; b_flush = 0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_params();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
